// File: rtl/datapath_param.sv
// Parametrised accumulator/register-file datapath with command handshake,
// two-beat register-pair load, decimal adjust, rotates and branch evaluation.
module datapath_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [3:0]                  cmd_op,
  input  logic [$clog2(NUM_REGS)-1:0] cmd_idx,
  input  logic [WIDTH-1:0]            cmd_imm,
  input  logic [WIDTH-1:0]            data_in,
  input  logic                        data_valid,
  input  logic                        test,
  output logic [WIDTH-1:0]            acc,
  output logic                        carry,
  output logic [WIDTH-1:0]            regval,
  output logic [2*WIDTH-1:0]          pair_out,
  output logic                        take_branch,
  output logic                        done
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PAIR_EVEN = 2'd1;
  localparam logic [1:0] ST_PAIR_ODD  = 2'd2;

  localparam logic [3:0] OP_LDM = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_XCH = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_CLB = 4'h7;
  localparam logic [3:0] OP_TCC = 4'h8;
  localparam logic [3:0] OP_DAA = 4'h9;
  localparam logic [3:0] OP_RAL = 4'hA;
  localparam logic [3:0] OP_RAR = 4'hB;
  localparam logic [3:0] OP_FIM = 4'hC;
  localparam logic [3:0] OP_JCN = 4'hD;
  localparam logic [3:0] OP_ISZ = 4'hE;

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             tb_q, tb_d;
  logic             done_q, done_d;
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       test_sync_q;

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rv, rv_inc;
  logic [WIDTH:0]   sum;
  logic [4:0]       nib_sum;
  logic [3:0]       cond;
  logic             t;
  logic             test_s;
  logic             accept;

  assign test_s    = test_sync_q[1];
  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rv        = regs_q[cmd_idx];
  assign rv_inc    = rv + ONE;
  assign cond      = cmd_imm[3:0];

  assign regval      = rv;
  assign pair_out    = {regs_q[cmd_idx & ~IDX_ONE], regs_q[cmd_idx | IDX_ONE]};
  assign acc         = acc_q;
  assign carry       = carry_q;
  assign take_branch = tb_q;
  assign done        = done_q;

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    tb_d    = tb_q;
    done_d  = 1'b0;
    state_d = state_q;
    idx_d   = idx_q;
    we      = 1'b0;
    waddr   = cmd_idx;
    wdata   = rv;
    sum     = '0;
    nib_sum = '0;
    t       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          done_d = (cmd_op != OP_FIM);
          case (cmd_op)
            OP_LDM: acc_d = cmd_imm;
            OP_LD:  acc_d = rv;
            OP_XCH: begin
              acc_d = rv;
              we    = 1'b1;
              wdata = acc_q;
            end
            OP_ADD: begin
              sum              = {1'b0, acc_q} + {1'b0, rv} + {{WIDTH{1'b0}}, carry_q};
              {carry_d, acc_d} = sum;
            end
            OP_SUB: begin
              // carry set means no borrow
              sum              = {1'b0, acc_q} + {1'b0, ~rv} + {{WIDTH{1'b0}}, ~carry_q};
              {carry_d, acc_d} = sum;
            end
            OP_INC: begin
              we    = 1'b1;
              wdata = rv_inc;
            end
            OP_CLB: begin
              acc_d   = '0;
              carry_d = 1'b0;
            end
            OP_TCC: begin
              acc_d   = {{(WIDTH-1){1'b0}}, carry_q};
              carry_d = 1'b0;
            end
            OP_DAA: begin
              if (acc_q[3:0] > 4'd9 || carry_q) begin
                nib_sum    = {1'b0, acc_q[3:0]} + 5'd6;
                acc_d[3:0] = nib_sum[3:0];
                if (nib_sum[4]) carry_d = 1'b1;
              end
            end
            OP_RAL: {carry_d, acc_d} = {acc_q, carry_q};
            OP_RAR: {acc_d, carry_d} = {carry_q, acc_q};
            OP_FIM: begin
              state_d = ST_PAIR_EVEN;
              idx_d   = cmd_idx;
            end
            OP_JCN: begin
              t    = (cond[2] && (acc_q == '0)) || (cond[1] && carry_q) || (cond[0] && !test_s);
              tb_d = cond[3] ? !t : t;
            end
            OP_ISZ: begin
              we    = 1'b1;
              wdata = rv_inc;
              tb_d  = (rv_inc != '0);
            end
            default: ;
          endcase
        end
      end
      ST_PAIR_EVEN: begin
        if (data_valid) begin
          we      = 1'b1;
          waddr   = idx_q & ~IDX_ONE;
          wdata   = data_in;
          state_d = ST_PAIR_ODD;
        end
      end
      ST_PAIR_ODD: begin
        if (data_valid) begin
          we      = 1'b1;
          waddr   = idx_q | IDX_ONE;
          wdata   = data_in;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      carry_q     <= 1'b1;
      tb_q        <= 1'b0;
      done_q      <= 1'b0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      test_sync_q <= 2'b11;
    end else begin
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      tb_q        <= tb_d;
      done_q      <= done_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      test_sync_q <= {test_sync_q[0], test};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_datapath_param.sv
// Scoreboard bench for datapath_param: a 4-bit/16-reg and an 8-bit/32-reg instance
// driven by directed commands; monitors compare outputs on every done pulse.
module tb_datapath_param;

  typedef struct {
    logic [7:0]  acc;
    logic        c;
    logic        tb;
    logic [7:0]  rv;
    logic [15:0] pair;
    logic        chk_pair;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] cmd_op = '0;
  logic [4:0] cmd_idx = '0;
  logic [7:0] cmd_imm = '0;
  logic [7:0] data_in = '0;
  logic       test = 1'b1;
  logic       v4 = 1'b0, v8 = 1'b0, dv4 = 1'b0, dv8 = 1'b0;

  logic        rdy4, c4, tb4, done4;
  logic [3:0]  acc4, rv4;
  logic [7:0]  pair4;
  logic        rdy8, c8, tb8, done8;
  logic [7:0]  acc8, rv8;
  logic [15:0] pair8;

  exp_t q4[$];
  exp_t q8[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clock = ~clock;

  datapath_param #(.WIDTH(4), .NUM_REGS(16)) dut4 (
    .clock(clock), .reset_n(reset_n), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx[3:0]), .cmd_imm(cmd_imm[3:0]), .data_in(data_in[3:0]),
    .data_valid(dv4), .test(test), .acc(acc4), .carry(c4), .regval(rv4), .pair_out(pair4),
    .take_branch(tb4), .done(done4)
  );

  datapath_param #(.WIDTH(8), .NUM_REGS(32)) dut8 (
    .clock(clock), .reset_n(reset_n), .cmd_valid(v8), .cmd_ready(rdy8), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_imm(cmd_imm), .data_in(data_in), .data_valid(dv8),
    .test(test), .acc(acc8), .carry(c8), .regval(rv8), .pair_out(pair8),
    .take_branch(tb8), .done(done8)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("acc4", {12'd0, acc4}, {8'd0, e.acc});
        check("carry4", {15'd0, c4}, {15'd0, e.c});
        check("take_branch4", {15'd0, tb4}, {15'd0, e.tb});
        check("regval4", {12'd0, rv4}, {8'd0, e.rv});
        if (e.chk_pair) check("pair_out4", {8'd0, pair4}, e.pair);
      end
    end
  end

  always @(negedge clock) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("acc8", {8'd0, acc8}, {8'd0, e.acc});
        check("carry8", {15'd0, c8}, {15'd0, e.c});
        check("take_branch8", {15'd0, tb8}, {15'd0, e.tb});
        check("regval8", {8'd0, rv8}, {8'd0, e.rv});
        if (e.chk_pair) check("pair_out8", pair8, e.pair);
      end
    end
  end

  task automatic push(input bit w8, input logic [7:0] eacc, input logic ec, input logic etb,
                      input logic [7:0] erv, input logic [15:0] epair, input logic chk);
    exp_t e;
    e.acc = eacc; e.c = ec; e.tb = etb; e.rv = erv; e.pair = epair; e.chk_pair = chk;
    if (w8) q8.push_back(e);
    else q4.push_back(e);
  endtask

  task automatic issue(input bit w8, input logic [3:0] op, input logic [4:0] idx,
                       input logic [7:0] imm, input logic [7:0] eacc, input logic ec,
                       input logic etb, input logic [7:0] erv);
    @(negedge clock);
    cmd_op = op; cmd_idx = idx; cmd_imm = imm;
    if (w8) v8 = 1'b1;
    else v4 = 1'b1;
    push(w8, eacc, ec, etb, erv, 16'd0, 1'b0);
    @(negedge clock);
    v4 = 1'b0; v8 = 1'b0;
  endtask

  task automatic fim(input bit w8, input logic [4:0] idx, input logic [7:0] b0,
                     input logic [7:0] b1, input int gap, input bit compete,
                     input logic [7:0] eacc, input logic ec, input logic etb,
                     input logic [7:0] erv, input logic [15:0] epair);
    @(negedge clock);
    cmd_op = 4'hC; cmd_idx = idx;
    if (w8) v8 = 1'b1;
    else v4 = 1'b1;
    @(negedge clock);
    if (compete) begin
      cmd_op = 4'h1; cmd_imm = 8'hFF; cmd_idx = idx ^ 5'h08;
    end else begin
      v4 = 1'b0; v8 = 1'b0;
    end
    check("fim_ready_even", {15'd0, w8 ? rdy8 : rdy4}, 16'd0);
    data_in = b0;
    if (w8) dv8 = 1'b1;
    else dv4 = 1'b1;
    @(negedge clock);
    dv4 = 1'b0; dv8 = 1'b0;
    check("fim_ready_odd", {15'd0, w8 ? rdy8 : rdy4}, 16'd0);
    repeat (gap) @(negedge clock);
    v4 = 1'b0; v8 = 1'b0;
    cmd_idx = idx; data_in = b1;
    if (w8) dv8 = 1'b1;
    else dv4 = 1'b1;
    push(w8, eacc, ec, etb, erv, epair, 1'b1);
    @(negedge clock);
    dv4 = 1'b0; dv8 = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("rst_acc4", {12'd0, acc4}, 16'd0);
    check("rst_carry4", {15'd0, c4}, 16'd1);
    check("rst_ready4", {15'd0, rdy4}, 16'd1);
    check("rst_tb4", {15'd0, tb4}, 16'd0);
    check("rst_done4", {15'd0, done4}, 16'd0);
    check("rst_acc8", {8'd0, acc8}, 16'd0);
    check("rst_carry8", {15'd0, c8}, 16'd1);
    for (int i = 0; i < 16; i++) begin
      cmd_idx = 5'(i);
      #1 check("rst_reg4", {12'd0, rv4}, 16'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;

    // accumulate, exchange, subtract, adjust, rotate on r3
    issue(0, 4'h1, 5'd3, 8'h7, 8'h7, 1, 0, 8'h0);
    issue(0, 4'h3, 5'd3, 8'h0, 8'h0, 1, 0, 8'h7);
    issue(0, 4'h4, 5'd3, 8'h0, 8'h8, 0, 0, 8'h7);
    issue(0, 4'h1, 5'd3, 8'h9, 8'h9, 0, 0, 8'h7);
    issue(0, 4'h4, 5'd3, 8'h0, 8'h0, 1, 0, 8'h7);
    issue(0, 4'h7, 5'd3, 8'h0, 8'h0, 0, 0, 8'h7);
    issue(0, 4'h1, 5'd3, 8'h3, 8'h3, 0, 0, 8'h7);
    issue(0, 4'h5, 5'd3, 8'h0, 8'hC, 0, 0, 8'h7);
    issue(0, 4'h9, 5'd3, 8'h0, 8'h2, 1, 0, 8'h7);
    issue(0, 4'hA, 5'd3, 8'h0, 8'h5, 0, 0, 8'h7);
    issue(0, 4'hB, 5'd3, 8'h0, 8'h2, 1, 0, 8'h7);
    issue(0, 4'h8, 5'd3, 8'h0, 8'h1, 0, 0, 8'h7);
    issue(0, 4'h6, 5'd3, 8'h0, 8'h1, 0, 0, 8'h8);
    issue(0, 4'h2, 5'd3, 8'h0, 8'h8, 0, 0, 8'h8);

    // pair load with a competing command and a 2-cycle beat gap
    fim(0, 5'd5, 8'hA, 8'h5, 2, 1, 8'h8, 0, 0, 8'h5, 16'h00A5);

    // reset in the middle of a pair load
    @(negedge clock);
    cmd_op = 4'hC; cmd_idx = 5'd5; v4 = 1'b1;
    @(negedge clock);
    v4 = 1'b0; data_in = 8'h3; dv4 = 1'b1;
    @(negedge clock);
    dv4 = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("midfim_ready", {15'd0, rdy4}, 16'd1);
    check("midfim_acc", {12'd0, acc4}, 16'd0);
    check("midfim_carry", {15'd0, c4}, 16'd1);
    cmd_idx = 5'd4;
    #1 check("midfim_r4", {12'd0, rv4}, 16'd0);
    #1 reset_n = 1'b1;
    @(negedge clock);
    data_in = 8'h7; dv4 = 1'b1;
    @(negedge clock);
    dv4 = 1'b0;
    check("idle_beat_ready", {15'd0, rdy4}, 16'd1);
    check("idle_beat_r4", {12'd0, rv4}, 16'd0);

    // branches
    issue(0, 4'h1, 5'd15, 8'hF, 8'hF, 1, 0, 8'h0);
    issue(0, 4'h3, 5'd15, 8'h0, 8'h0, 1, 0, 8'hF);
    issue(0, 4'hE, 5'd15, 8'h0, 8'h0, 1, 0, 8'h0);
    issue(0, 4'hD, 5'd15, 8'h4, 8'h0, 1, 1, 8'h0);
    issue(0, 4'hD, 5'd15, 8'hC, 8'h0, 1, 0, 8'h0);
    @(negedge clock);
    test = 1'b0;
    repeat (3) @(negedge clock);
    issue(0, 4'hD, 5'd15, 8'h1, 8'h0, 1, 1, 8'h0);
    issue(0, 4'hD, 5'd15, 8'hA, 8'h0, 1, 0, 8'h0);
    issue(0, 4'hE, 5'd15, 8'h0, 8'h0, 1, 1, 8'h1);
    issue(0, 4'h2, 5'd15, 8'h0, 8'h1, 1, 1, 8'h1);

    // wide instance
    issue(1, 4'h1, 5'd31, 8'h01, 8'h01, 1, 0, 8'h00);
    issue(1, 4'h3, 5'd31, 8'h00, 8'h00, 1, 0, 8'h01);
    issue(1, 4'h7, 5'd31, 8'h00, 8'h00, 0, 0, 8'h01);
    issue(1, 4'h1, 5'd31, 8'hFF, 8'hFF, 0, 0, 8'h01);
    issue(1, 4'h4, 5'd31, 8'h00, 8'h00, 1, 0, 8'h01);
    fim(1, 5'd30, 8'h12, 8'h34, 1, 0, 8'h00, 1, 0, 8'h12, 16'h1234);

    repeat (4) @(negedge clock);
    check("pending4", 16'(q4.size()), 16'd0);
    check("pending8", 16'(q8.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
